// File: rtl/reg_scan_pkg.sv
// Shared definitions for the register-file scan engine: controller states and
// stream-direction codes.
package reg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_LOAD = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/reg_scan.sv
// Register-file scan engine: dumps all N registers onto a valid/ready stream,
// or loads them from one, flagging loads whose framing disagrees with N.
module reg_scan
  import reg_scan_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [REG_BITS-1:0] rf_index,
  input  logic [WIDTH-1:0]    rf_rd_data,
  output logic                rf_write,
  output logic [WIDTH-1:0]    rf_write_data,
  output logic [WIDTH-1:0]    m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  input  logic [WIDTH-1:0]    s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_last
);

  localparam int N = 1 << REG_BITS;
  // One extra bit so the dump counter can sit at N once every word is queued.
  localparam logic [REG_BITS:0] LAST_IDX = (REG_BITS + 1)'(N - 1);

  state_t              state;
  logic [REG_BITS:0]   cnt;
  logic                dump_ld;
  logic                dump_hs;
  logic                load_hs;
  logic                cnt_at_last;

  assign cnt_at_last = (cnt == LAST_IDX);
  assign dump_hs     = m_valid && m_ready;
  // Refill the output word whenever it is empty or being consumed this edge.
  assign dump_ld     = (state == ST_DUMP) && (cnt <= LAST_IDX) && (!m_valid || m_ready);
  assign load_hs     = (state == ST_LOAD) && s_valid;

  assign busy          = (state != ST_IDLE);
  assign s_ready       = (state == ST_LOAD);
  assign rf_write      = load_hs;
  assign rf_write_data = s_data;
  assign rf_index      = (state == ST_DUMP || state == ST_LOAD) ? cnt[REG_BITS-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= '0;
            err   <= 1'b0;
            state <= (mode == MODE_LOAD) ? ST_LOAD : ST_DUMP;
          end
        end
        ST_DUMP: begin
          if (dump_ld) begin
            m_data  <= rf_rd_data;
            m_last  <= cnt_at_last;
            m_valid <= 1'b1;
            cnt     <= cnt + 1'b1;
          end else if (dump_hs) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end
          if (dump_hs && m_last) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b1;
            state   <= ST_FIN;
          end
        end
        ST_LOAD: begin
          if (load_hs) begin
            cnt <= cnt + 1'b1;
            if (s_last || cnt_at_last) begin
              // Framing is good only when the marked last word is register N-1.
              err   <= (s_last != cnt_at_last);
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_scan.sv
// Randomized bench for reg_scan: a register-file array plus a per-register
// reference image predicts every dumped word and every load's final contents.
module tb_reg_scan;

  localparam int WIDTH    = 16;
  localparam int REG_BITS = 4;
  localparam int N        = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start, mode;
  logic                busy, done, err;
  logic [REG_BITS-1:0] rf_index;
  logic [WIDTH-1:0]    rf_rd_data;
  logic                rf_write;
  logic [WIDTH-1:0]    rf_write_data;
  logic [WIDTH-1:0]    m_data;
  logic                m_valid, m_ready, m_last;
  logic [WIDTH-1:0]    s_data;
  logic                s_valid, s_ready, s_last;

  reg_scan #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err),
    .rf_index(rf_index), .rf_rd_data(rf_rd_data),
    .rf_write(rf_write), .rf_write_data(rf_write_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last)
  );

  always #5 clk = ~clk;

  // Register file with hardwired register 0; bench-side port used only to preload.
  logic [WIDTH-1:0]    rf [N];
  logic                pl_we;
  logic [REG_BITS-1:0] pl_idx;
  logic [WIDTH-1:0]    pl_data;

  always @(posedge clk) begin
    if (pl_we) rf[pl_idx] <= pl_data;
    else if (rf_write && rf_index != 0) rf[rf_index] <= rf_write_data;
  end
  assign rf_rd_data = (rf_index == 0) ? '0 : rf[rf_index];

  logic [WIDTH-1:0] model [N];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [WIDTH-1:0] base);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      pl_we   = 1'b1;
      pl_idx  = REG_BITS'(i);
      pl_data = base + WIDTH'(i);
      model[i] = (i == 0) ? '0 : base + WIDTH'(i);
    end
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 1; i < N; i++) chk(tag, rf[i], model[i]);
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,..., 2 = random ready.
  task automatic dump(input int rmode, input bit poke_start);
    int got = 0;
    int first = -1;
    int last = -1;
    bit fin = 1'b0;
    bit stall = 1'b0;
    logic [WIDTH-1:0] pd = '0;
    logic pl = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (stall) begin
        chk("dump_hold_valid", m_valid, 1);
        chk("dump_hold_data", m_data, pd);
        chk("dump_hold_last", m_last, pl);
      end
      if (got == N) begin
        chk("dump_done", done, 1);
        chk("dump_mvalid_after", m_valid, 0);
        @(negedge clk);
        chk("dump_done_pulse", done, 0);
        chk("dump_idle", busy, 0);
        start = 1'b0;
        fin = 1'b1;
      end else begin
        case (rmode)
          0: m_ready = 1'b1;
          1: m_ready = (cyc % 3 == 0);
          default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (poke_start) begin
          start = 1'($urandom_range(0, 1));
          mode  = 1'b1;
        end
        if (m_valid && m_ready) begin
          chk("dump_word", m_data, model[got]);
          chk("dump_last", m_last, (got == N - 1));
          if (first < 0) first = cyc;
          last = cyc;
          got++;
        end
        stall = m_valid && !m_ready;
        pd = m_data;
        pl = m_last;
        @(negedge clk);
      end
    end
    if (!fin) chk("dump_timeout", 0, 1);
    chk("dump_count", got, N);
    chk("dump_err_clear", err, 0);
    if (rmode == 0) chk("dump_rate", last - first, N - 1);
    start = 1'b0; mode = 1'b0; m_ready = 1'b1;
  endtask

  // last_pos: index carrying s_last (-1: never). rst_at: word during which reset hits (-1: none).
  task automatic load(input int last_pos, input logic [WIDTH-1:0] base, input int rst_at);
    logic [WIDTH-1:0] w [N];
    int  k;
    bit  err_exp;
    bit  aborted = 1'b0;
    k = (last_pos >= 0 && last_pos < N) ? last_pos : N - 1;
    err_exp = (last_pos != N - 1);
    for (int i = 0; i < N; i++) w[i] = (base != 0) ? base + WIDTH'(i) : WIDTH'($urandom);
    @(negedge clk);
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_sready", s_ready, 1);
    for (int i = 0; i <= k && !aborted; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      s_valid = 1'b1;
      s_data  = w[i];
      s_last  = (i == last_pos);
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mlast", m_last, 0);
        chk("rst_rfwrite", rf_write, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_mdata", m_data, 0);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        if (i != 0) model[i] = w[i];
      end
    end
    if (!aborted) begin
      chk("load_done", done, 1);
      chk("load_sready_fin", s_ready, 0);
      chk("load_err", err, err_exp);
      @(negedge clk);
      chk("load_done_pulse", done, 0);
      chk("load_idle", busy, 0);
      chk("load_err_held", err, err_exp);
    end
    check_rf(aborted ? "rf_after_reset" : "rf_after_load");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; m_ready = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    pl_we = 1'b0; pl_idx = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_mvalid", m_valid, 0);
    chk("reset_mlast", m_last, 0);
    chk("reset_sready", s_ready, 0);
    chk("reset_rfwrite", rf_write, 0);
    chk("reset_mdata", m_data, 0);
    chk("reset_rfindex", rf_index, 0);
    rst_n = 1'b1;

    preload(16'h1000);
    dump(0, 1'b0);
    dump(1, 1'b1);
    load(N - 1, 16'hA000, -1);
    dump(2, 1'b0);
    load(3, 16'h0000, -1);
    dump(0, 1'b0);
    load(-1, 16'h0000, -1);
    dump(1, 1'b0);
    load(N - 1, 16'h0000, 7);
    dump(0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      load($urandom_range(0, N - 1), 16'h0000, -1);
      dump(2, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_scan.md
REG_SCAN -- requirements
Module: reg_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register data width.
REQ-002 SHALL have parameter REG_BITS, default 4, register index width (N = 2^REG_BITS registers).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  begin operation; sampled only in IDLE.
REQ-006 SHALL have port mode  in  1  0 = dump (register file to stream), 1 = load (stream to register file); sampled with start.
REQ-007 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-008 SHALL have port done  out  1  one-cycle pulse at the end of an operation.
REQ-009 SHALL have port err  out  1  load framing error; held until the next accepted start.
REQ-010 SHALL have port rf_index  out  REG_BITS  drives the register file's write/read-A index.
REQ-011 SHALL have port rf_rd_data  in  WIDTH  register file read-A data, combinational from rf_index.
REQ-012 SHALL have port rf_write  out  1  register file write enable.
REQ-013 SHALL have port rf_write_data  out  WIDTH  register file write data.
REQ-014 SHALL have ports m_data out WIDTH, m_valid out 1, m_ready in 1, m_last out 1  dump stream.
REQ-015 SHALL have ports s_data in WIDTH, s_valid in 1, s_ready out 1, s_last in 1  load stream.

Function
REQ-016 SHALL implement states IDLE, DUMP, LOAD, FIN; start=1 in IDLE moves to DUMP (mode=0) or LOAD (mode=1), counter cleared to 0, err cleared.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 DUMP: rf_index SHALL equal the counter; output register (m_data, m_last) SHALL load rf_rd_data when counter <= N-1 and (m_valid=0 or m_ready=1), counter then increments.
REQ-019 DUMP: first m_valid SHALL assert the cycle after start is accepted; m_data/m_valid/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-020 DUMP: with m_ready held high, throughput SHALL be one word per cycle; N words emitted in index order 0..N-1.
REQ-021 DUMP: m_last SHALL be high exactly with word N-1; index 0 word is whatever rf_rd_data returns (0 for hardwired register 0).
REQ-022 DUMP: handshake of the m_last word SHALL move to FIN; m_valid low the following cycle.
REQ-023 LOAD: s_ready SHALL be 1 in LOAD and 0 in every other state.
REQ-024 LOAD: rf_write SHALL equal s_valid and s_ready combinationally, with rf_index = counter and rf_write_data = s_data, so the write lands on the handshake edge.
REQ-025 LOAD: each handshake SHALL increment the counter; handshake with s_last=1 or counter = N-1 SHALL move to FIN.
REQ-026 LOAD: s_last=1 with counter < N-1 SHALL still write that word, end the load, and set err.
REQ-027 LOAD: counter = N-1 handshake with s_last=0 SHALL write the word, end the load, and set err.
REQ-028 FIN: done SHALL pulse for exactly one cycle, then state returns to IDLE.
REQ-029 rf_write SHALL be 0 in IDLE, DUMP and FIN; rf_index SHALL be 0 in IDLE.
REQ-030 counter SHALL be REG_BITS+1 bits wide so N is representable without wrap.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, counter 0, and busy, done, err, m_valid, m_last, rf_write, s_ready low, m_data 0.
REQ-032 Reset mid-operation SHALL abort without further writes; already-written registers keep their values (register file has no reset).

Structure
REQ-033 State encoding and mode constants SHALL reside in the shared package; WIDTH/REG_BITS remain module parameters.
REQ-034 Single module; no sub-module.

Verification
REQ-035 Registers preloaded r[i]=0x1000+i, start mode=0, m_ready=1 -> 16 words 0x0000,0x1001..0x100F on consecutive cycles, m_last on 0x100F, done one cycle after.
REQ-036 Dump with m_ready toggling 1,0,0,1... -> no word dropped or duplicated, data stable while stalled.
REQ-037 start mode=1, 16 words 0xA000+i, s_last on word 15 -> registers 1..15 read back 0xA001..0xA00F, err=0, done pulse.
REQ-038 Load with s_last on word 3 -> registers 1..3 written, 4..15 unchanged, err=1.
REQ-039 rst_n low during word 7 of a load -> all outputs low same cycle, registers 8..15 unchanged, start after release accepted normally.
